// File: rtl/acc_reg_bank_if.sv
// ---------------------------------------------------------------------------
// acc_reg_bank_if
// Bus bundle for the accumulator register bank.
//   master : drives sel and the operation strobes/operands, observes reads
//   slave  : the register bank itself
// Signals
//   sel        entry index for per-entry operations and the read port
//   clr        clear entry[sel]
//   clr_all    clear every entry
//   incre      entry[sel] + 1
//   decre      entry[sel] - 1
//   write_en   load data_in into entry[sel]
//   alu_to_ac  load alu_out into entry[sel]
//   accum_en   entry[sel] + data_in
//   data_in    load/accumulate operand
//   alu_out    ALU writeback operand
//   data_out   entry[sel] (combinational read)
//   zero       entry[sel] == 0
//   ovf        sticky overflow/underflow flag of entry[sel]
// ---------------------------------------------------------------------------
interface acc_reg_bank_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
);
  logic [$clog2(DEPTH)-1:0] sel;
  logic                     clr;
  logic                     clr_all;
  logic                     incre;
  logic                     decre;
  logic                     write_en;
  logic                     alu_to_ac;
  logic                     accum_en;
  logic [WIDTH-1:0]         data_in;
  logic [WIDTH-1:0]         alu_out;
  logic [WIDTH-1:0]         data_out;
  logic                     zero;
  logic                     ovf;

  modport master (
    output sel, clr, clr_all, incre, decre, write_en, alu_to_ac, accum_en,
           data_in, alu_out,
    input  data_out, zero, ovf
  );

  modport slave (
    input  sel, clr, clr_all, incre, decre, write_en, alu_to_ac, accum_en,
           data_in, alu_out,
    output data_out, zero, ovf
  );
endinterface

// File: rtl/acc_reg_bank.sv
// ---------------------------------------------------------------------------
// acc_reg_bank
// DEPTH accumulator entries of WIDTH bits, each with a sticky overflow bit.
// One operation per clock, chosen by fixed priority:
//   clr_all > clr > incre > decre > write_en > alu_to_ac > accum_en
// Arithmetic wraps (SAT_EN=0) or clamps (SAT_EN=1); either way an
// overflow/underflow sets the entry's sticky ovf bit.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, clears every entry and ovf bit
//   bus  acc_reg_bank_if.slave (operation strobes, operands, read port)
// ---------------------------------------------------------------------------
module acc_reg_bank #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 4,
  parameter int SAT_EN = 0
) (
  input logic           clk,
  input logic           rst,
  acc_reg_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] entry [DEPTH];
  logic [DEPTH-1:0] ovf_bits;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt_val;
  logic             nxt_ovf;
  logic             upd;
  logic [WIDTH:0]   res;

  // Unsigned add; result MSB is the carry-out, low bits are the stored value.
  function automatic logic [WIDTH:0] add_sat(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[WIDTH] && (SAT_EN != 0)) sum[WIDTH-1:0] = ONES;
    return sum;
  endfunction

  // Unsigned subtract; result MSB is the borrow, low bits are the stored value.
  function automatic logic [WIDTH:0] sub_sat(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[WIDTH] && (SAT_EN != 0)) diff[WIDTH-1:0] = '0;
    return diff;
  endfunction

  // Next value of the selected entry. clr_all is resolved in the register
  // process because it touches every entry.
  always_comb begin
    cur     = entry[bus.sel];
    nxt_val = cur;
    nxt_ovf = ovf_bits[bus.sel];
    upd     = 1'b0;
    res     = '0;
    if (bus.clr) begin
      nxt_val = '0;
      nxt_ovf = 1'b0;
      upd     = 1'b1;
    end else if (bus.incre) begin
      res     = add_sat(cur, ONE);
      nxt_val = res[WIDTH-1:0];
      nxt_ovf = ovf_bits[bus.sel] | res[WIDTH];
      upd     = 1'b1;
    end else if (bus.decre) begin
      res     = sub_sat(cur, ONE);
      nxt_val = res[WIDTH-1:0];
      nxt_ovf = ovf_bits[bus.sel] | res[WIDTH];
      upd     = 1'b1;
    end else if (bus.write_en) begin
      nxt_val = bus.data_in;
      nxt_ovf = 1'b0;
      upd     = 1'b1;
    end else if (bus.alu_to_ac) begin
      nxt_val = bus.alu_out;
      nxt_ovf = 1'b0;
      upd     = 1'b1;
    end else if (bus.accum_en) begin
      res     = add_sat(cur, bus.data_in);
      nxt_val = res[WIDTH-1:0];
      nxt_ovf = ovf_bits[bus.sel] | res[WIDTH];
      upd     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      ovf_bits <= '0;
    end else if (bus.clr_all) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      ovf_bits <= '0;
    end else if (upd) begin
      entry[bus.sel]    <= nxt_val;
      ovf_bits[bus.sel] <= nxt_ovf;
    end
  end

  assign bus.data_out = entry[bus.sel];
  assign bus.zero     = (entry[bus.sel] == '0);
  assign bus.ovf      = ovf_bits[bus.sel];

endmodule

// File: doc/acc_reg_bank.md
ACC_REG_BANK -- requirements
Module: acc_reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning bit width of every accumulator entry and data port.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of accumulator entries (legal: power of two, >= 2).
REQ-003 The block SHALL have parameter SAT_EN, default 0, meaning 0 = wrap-around arithmetic, 1 = saturating arithmetic.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sel  input  log2(DEPTH)  index of the entry targeted by every per-entry operation and read.
REQ-007 clr  input  1  clear the selected entry.
REQ-008 clr_all  input  1  clear every entry.
REQ-009 incre  input  1  selected entry + 1.
REQ-010 decre  input  1  selected entry - 1.
REQ-011 write_en  input  1  load data_in into the selected entry.
REQ-012 alu_to_ac  input  1  load alu_out into the selected entry.
REQ-013 accum_en  input  1  selected entry + data_in (unsigned).
REQ-014 data_in  input  WIDTH  load/accumulate operand.
REQ-015 alu_out  input  WIDTH  ALU result for writeback.
REQ-016 data_out  output  WIDTH  current value of entry[sel], combinational read of registered state.
REQ-017 zero  output  1  high when entry[sel] == 0.
REQ-018 ovf  output  1  sticky overflow/underflow flag of entry[sel].

Function
REQ-019 The block SHALL hold DEPTH entries of WIDTH bits plus one sticky ovf bit per entry.
REQ-020 At most one operation SHALL execute per clock, by fixed priority: clr_all > clr > incre > decre > write_en > alu_to_ac > accum_en; lower-priority requests in the same cycle are dropped.
REQ-021 Only entry[sel] SHALL change for per-entry operations; all other entries hold.
REQ-022 clr_all SHALL set all entries and all ovf bits to 0 in one cycle, regardless of sel.
REQ-023 clr SHALL set entry[sel] and ovf[sel] to 0.
REQ-024 write_en and alu_to_ac SHALL load the operand and clear ovf[sel].
REQ-025 incre at all-ones: SAT_EN=0 -> result 0; SAT_EN=1 -> result stays all-ones; ovf[sel] set in both.
REQ-026 decre at 0: SAT_EN=0 -> result all-ones; SAT_EN=1 -> result stays 0; ovf[sel] set in both.
REQ-027 accum_en SHALL compute a WIDTH+1-bit sum; on carry-out, SAT_EN=0 stores low WIDTH bits, SAT_EN=1 stores all-ones; ovf[sel] set in both.
REQ-028 Arithmetic without overflow/underflow SHALL leave ovf[sel] unchanged (sticky).
REQ-029 Results SHALL be visible on data_out, zero and ovf one clock after the requesting edge (latency 1); a change of sel SHALL update outputs in the same cycle with no clock.
REQ-030 With no operation asserted, all state SHALL hold.
REQ-031 Increment and decrement SHALL use a WIDTH-bit constant 1, never a fixed-width literal.

Reset
REQ-032 rst high SHALL immediately (without clk) force all entries to 0 and all ovf bits to 0, so data_out = 0, zero = 1, ovf = 0.
REQ-033 rst SHALL override every operation, including one asserted on the same edge; reset release mid-sequence SHALL resume from the all-zero state on the next rising edge.

Verification
REQ-034 Reset: load 0x123456 into entry 2, assert rst between edges -> data_out = 0, zero = 1, ovf = 0 before the next edge.
REQ-035 Wrap vs saturate: entry 0 = 0xFFFFFF, incre -> SAT_EN=0 gives 0x000000 ovf=1; SAT_EN=1 gives 0xFFFFFF ovf=1; then decre from 0 on entry 1 -> 0xFFFFFF (wrap) or 0x000000 (sat), ovf=1.
REQ-036 Accumulate: entry 3 = 0xFFFFF0, accum_en data_in = 0x20 -> SAT_EN=0 gives 0x000010 ovf=1; next accum_en data_in = 1 -> 0x000011, ovf still 1; write_en 5 -> 0x000005 ovf=0.
REQ-037 Priority: same cycle incre, write_en (data_in 0x100), accum_en on entry 1 = 7 -> 0x000008; same cycle clr + incre -> 0.
REQ-038 Isolation: load distinct values into all 4 entries, sweep sel -> each reads back unchanged; clr_all with sel = 2 -> all four read 0, zero = 1 for every sel.
